// File: rtl/bitfusion_pkg.sv
// bitfusion_pkg
// Shared encodings and defaults for the bit-serial weight path.
//   BW_2B / BW_4B / BW_8B : one-hot weight bitwidth encodings
//   beats_for(bw)         : index of the last beat in a group (N-1)
//   DEFAULT_LANES / DEFAULT_PSUM_W : default lane count and partial-sum width
package bitfusion_pkg;

    localparam logic [2:0] BW_2B = 3'b001;
    localparam logic [2:0] BW_4B = 3'b010;
    localparam logic [2:0] BW_8B = 3'b100;

    localparam int DEFAULT_LANES  = 16;
    localparam int DEFAULT_PSUM_W = 16;

    // Any encoding that is not one of the three legal ones behaves as 2-bit.
    function automatic logic [1:0] beats_for(input logic [2:0] bw);
        logic [1:0] last_idx;
        case (bw)
            BW_4B:   last_idx = 2'd1;
            BW_8B:   last_idx = 2'd3;
            default: last_idx = 2'd0;
        endcase
        return last_idx;
    endfunction

endpackage

// File: rtl/lane_shift_acc.sv
// lane_shift_acc
// One lane of the output recombiner: sign-extends the slice partial sum,
// shifts it to its slice weight and accumulates it across a group.
//   clk, rst : clock and asynchronous active-high reset
//   en       : a beat is accepted this cycle
//   first    : the beat is slice 0 (accumulation restarts)
//   last     : the beat closes the group (result register loads)
//   shift    : left shift for this slice (2 * slice index)
//   psum     : signed partial sum for this slice
//   result   : signed recombined result of the most recent group
module lane_shift_acc #(
    parameter int PSUM_W = 16,
    parameter int OUT_W  = PSUM_W + 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              first,
    input  logic              last,
    input  logic [2:0]        shift,
    input  logic [PSUM_W-1:0] psum,
    output logic [OUT_W-1:0]  result
);

    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] contrib;
    logic [OUT_W-1:0] sum;

    // Slice 0 ignores whatever the accumulator holds, so a stale value can
    // never leak into a new group. Addition wraps at OUT_W bits.
    always_comb begin
        ext     = {{(OUT_W-PSUM_W){psum[PSUM_W-1]}}, psum};
        contrib = ext << shift;
        sum     = (first ? '0 : acc) + contrib;
    end

    // The final beat hands the sum to the result register and clears the
    // accumulator; any other beat just keeps the running sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            result <= '0;
        end else if (en) begin
            if (last) begin
                result <= sum;
                acc    <= '0;
            end else begin
                acc    <= sum;
            end
        end
    end

endmodule

// File: rtl/out_shift_acc.sv
// out_shift_acc
// Recombines per-lane bit-serial partial sums (LSB 2-bit slice first) into
// full-precision results over 1, 2 or 4 beats, presented on a valid/ready
// output register.
//   clk, RST        : clock and asynchronous active-high reset
//   weight_bitwidth : 001/010/100 = 2/4/8-bit weights, sampled on slice 0
//   in_valid/in_ready, psum_in   : slice beat handshake, LANES x PSUM_W
//   out_valid/out_ready, data_out: result handshake, LANES x OUT_W
module out_shift_acc
    import bitfusion_pkg::*;
#(
    parameter int LANES  = DEFAULT_LANES,
    parameter int PSUM_W = DEFAULT_PSUM_W,
    parameter int OUT_W  = PSUM_W + 6
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic [2:0]             weight_bitwidth,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*PSUM_W-1:0] psum_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0]  data_out
);

    logic [1:0] slice_ptr;
    logic [2:0] mode_q;
    logic       accept;
    logic       first;
    logic       last;
    logic [1:0] last_idx;
    logic [2:0] shift;

    // On slice 0 the live bitwidth decides the group length; after that the
    // latched mode does, so mid-group bitwidth changes are ignored.
    always_comb begin
        in_ready = !(out_valid && !out_ready);
        accept   = in_valid && in_ready;
        first    = (slice_ptr == 2'd0);
        last_idx = first ? beats_for(weight_bitwidth) : beats_for(mode_q);
        last     = (slice_ptr == last_idx);
        shift    = {slice_ptr, 1'b0};
    end

    // A final beat always (re)loads the result and keeps out_valid high,
    // even if the previous result is consumed in the same cycle.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            slice_ptr <= 2'd0;
            mode_q    <= BW_2B;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                if (first) begin
                    mode_q <= weight_bitwidth;
                end
                slice_ptr <= last ? 2'd0 : slice_ptr + 2'd1;
            end
            if (accept && last) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        lane_shift_acc #(
            .PSUM_W(PSUM_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk   (clk),
            .rst   (RST),
            .en    (accept),
            .first (first),
            .last  (last),
            .shift (shift),
            .psum  (psum_in[k*PSUM_W +: PSUM_W]),
            .result(data_out[k*OUT_W +: OUT_W])
        );
    end

endmodule

// File: tb/tb_out_shift_acc.sv
// tb_out_shift_acc
// Directed bench for out_shift_acc: each scenario task drives beats and
// compares outputs against hand-computed results.
module tb_out_shift_acc;

    localparam int LANES  = 16;
    localparam int PSUM_W = 16;
    localparam int OUT_W  = 22;

    logic                     clk;
    logic                     RST;
    logic [2:0]               weight_bitwidth;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*PSUM_W-1:0]  psum_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*OUT_W-1:0]   data_out;

    int checks;
    int errors;

    out_shift_acc #(
        .LANES (LANES),
        .PSUM_W(PSUM_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk            (clk),
        .RST            (RST),
        .weight_bitwidth(weight_bitwidth),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .psum_in        (psum_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_out       (data_out)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Same partial sum on every lane.
    function automatic logic [LANES*PSUM_W-1:0] psum_all(input logic [PSUM_W-1:0] v);
        logic [LANES*PSUM_W-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*PSUM_W +: PSUM_W] = v;
        return r;
    endfunction

    // One lane carries v, all others zero.
    function automatic logic [LANES*PSUM_W-1:0] psum_one(input int lane, input logic [PSUM_W-1:0] v);
        logic [LANES*PSUM_W-1:0] r;
        r = '0;
        r[lane*PSUM_W +: PSUM_W] = v;
        return r;
    endfunction

    function automatic logic [LANES*OUT_W-1:0] out_all(input logic [OUT_W-1:0] v);
        logic [LANES*OUT_W-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*OUT_W +: OUT_W] = v;
        return r;
    endfunction

    function automatic logic [LANES*OUT_W-1:0] out_one(input int lane, input logic [OUT_W-1:0] v);
        logic [LANES*OUT_W-1:0] r;
        r = '0;
        r[lane*OUT_W +: OUT_W] = v;
        return r;
    endfunction

    // Present one beat, let the next rising edge take it, then sample 1 time
    // unit later with in_valid dropped (a following beat re-raises it at once).
    task automatic send_beat(input logic [2:0] bw, input logic [LANES*PSUM_W-1:0] p);
        weight_bitwidth = bw;
        psum_in         = p;
        in_valid        = 1'b1;
        @(posedge clk);
        #1;
        in_valid        = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RST             = 1'b1;
        in_valid        = 1'b0;
        out_ready       = 1'b1;
        weight_bitwidth = 3'b001;
        psum_in         = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (data_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data_out: got %h expected 0", data_out);
        end
        RST = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_2bit_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_beat(3'b001, psum_all(-16'sd3));
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", i, out_valid);
            end
            checks++;
            if (data_out !== out_all(-22'sd3)) begin
                errors++;
                $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", i, data_out, out_all(-22'sd3));
            end
        end
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_4bit();
        send_beat(3'b010, psum_one(0, 16'sd5));
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bw4_mid_valid: got %b expected 0", out_valid);
        end
        send_beat(3'b010, psum_one(0, -16'sd2));
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bw4_end_valid: got %b expected 1", out_valid);
        end
        checks++;
        if (data_out !== out_one(0, -22'sd3)) begin
            errors++;
            $display("[TB] FAIL bw4_data: got %h expected %h", data_out, out_one(0, -22'sd3));
        end
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bw4_single_pulse: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_8bit_sparse();
        logic [PSUM_W-1:0] dense[4];
        logic [PSUM_W-1:0] sparse[4];
        dense  = '{16'sd1, 16'sd2, 16'sd3, -16'sd1};
        sparse = '{16'sd1, 16'sd2, 16'sd0, -16'sd1};
        // Group 1: 1 + 2*4 + 3*16 - 64 = -7 on lane 7.
        for (int s = 0; s < 4; s++) begin
            send_beat(3'b100, psum_one(7, dense[s]));
            if (s < 3) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL bw8_mid_valid[%0d]: got %b expected 0", s, out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || data_out !== out_one(7, -22'sd7)) begin
            errors++;
            $display("[TB] FAIL bw8_dense: valid %b data %h expected valid 1 data %h", out_valid, data_out, out_one(7, -22'sd7));
        end
        // Group 2: slice 2 is an all-zero beat, so 1 + 8 - 64 = -55.
        for (int s = 0; s < 4; s++) begin
            send_beat(3'b100, (s == 2) ? '0 : psum_one(7, sparse[s]));
        end
        checks++;
        if (out_valid !== 1'b1 || data_out !== out_one(7, -22'sd55)) begin
            errors++;
            $display("[TB] FAIL bw8_sparse: valid %b data %h expected valid 1 data %h", out_valid, data_out, out_one(7, -22'sd55));
        end
        // Pointer must have wrapped: a 2-bit beat completes at once.
        send_beat(3'b001, psum_all(16'sd9));
        checks++;
        if (out_valid !== 1'b1 || data_out !== out_all(22'sd9)) begin
            errors++;
            $display("[TB] FAIL bw8_wrap: valid %b data %h expected valid 1 data %h", out_valid, data_out, out_all(22'sd9));
        end
        idle_cycle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        send_beat(3'b001, psum_all(16'sd4));
        checks++;
        if (out_valid !== 1'b1 || data_out !== out_all(22'sd4)) begin
            errors++;
            $display("[TB] FAIL bp_first: valid %b data %h expected valid 1 data %h", out_valid, data_out, out_all(22'sd4));
        end
        out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_in_ready_low: got %b expected 0", in_ready);
        end
        // Offered beat must not be taken while the result is held.
        send_beat(3'b001, psum_all(16'sd6));
        checks++;
        if (out_valid !== 1'b1 || data_out !== out_all(22'sd4)) begin
            errors++;
            $display("[TB] FAIL bp_hold: valid %b data %h expected valid 1 data %h", out_valid, data_out, out_all(22'sd4));
        end
        // Consume and replace in the same cycle.
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_in_ready_high: got %b expected 1", in_ready);
        end
        send_beat(3'b001, psum_all(16'sd6));
        checks++;
        if (out_valid !== 1'b1 || data_out !== out_all(22'sd6)) begin
            errors++;
            $display("[TB] FAIL bp_replace: valid %b data %h expected valid 1 data %h", out_valid, data_out, out_all(22'sd6));
        end
        idle_cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_mode_switch();
        // Beat 0 latches 8-bit; later beats present 2-bit but must be ignored.
        send_beat(3'b100, psum_all(16'sd1));
        send_beat(3'b001, psum_all(16'sd1));
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL switch_mid_valid: got %b expected 0", out_valid);
        end
        send_beat(3'b001, psum_all(16'sd1));
        send_beat(3'b001, psum_all(16'sd1));
        checks++;
        if (out_valid !== 1'b1 || data_out !== out_all(22'sd85)) begin
            errors++;
            $display("[TB] FAIL switch_group: valid %b data %h expected valid 1 data %h", out_valid, data_out, out_all(22'sd85));
        end
        send_beat(3'b001, psum_all(16'sd7));
        checks++;
        if (out_valid !== 1'b1 || data_out !== out_all(22'sd7)) begin
            errors++;
            $display("[TB] FAIL switch_next_2b: valid %b data %h expected valid 1 data %h", out_valid, data_out, out_all(22'sd7));
        end
    endtask

    task automatic test_reset_mid_group();
        send_beat(3'b100, psum_all(16'sd3));
        send_beat(3'b100, psum_all(16'sd3));
        // Asynchronous reset between edges must clear outputs immediately.
        RST = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0 || data_out !== '0) begin
            errors++;
            $display("[TB] FAIL rst_async: valid %b data %h expected valid 0 data 0", out_valid, data_out);
        end
        #1;
        RST = 1'b0;
        @(posedge clk);
        #1;
        send_beat(3'b010, psum_all(16'sd1));
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_restart_mid: got %b expected 0", out_valid);
        end
        send_beat(3'b010, psum_all(16'sd1));
        checks++;
        if (out_valid !== 1'b1 || data_out !== out_all(22'sd5)) begin
            errors++;
            $display("[TB] FAIL rst_restart_group: valid %b data %h expected valid 1 data %h", out_valid, data_out, out_all(22'sd5));
        end
        idle_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_2bit_back_to_back();
        test_4bit();
        test_8bit_sparse();
        test_backpressure();
        test_mode_switch();
        test_reset_mid_group();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
